// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, FSM states and
// the iterative engine's mode select.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  typedef enum logic {MD_MUL, MD_DIV} md_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per
// clock over WIDTH steps.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  md_t              mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_step;
  logic [WIDTH-1:0]   dvs;
  logic [SHW-1:0]     cnt;
  logic               busy_q;
  md_t                md;
  logic [WIDTH:0]     add_t;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     sub_t;

  // MUL: {hi,lo} starts as {0,a}; add b into hi when lo[0] is set, then shift right.
  // DIV: {rem,quo} starts as {0,a}; shift left, try subtracting b, restore on borrow.
  always_comb begin
    add_t  = '0;
    rem_sh = '0;
    sub_t  = '0;
    p_step = p;
    if (md == MD_MUL) begin
      add_t  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, dvs} : '0);
      p_step = {add_t, p[WIDTH-1:1]};
    end else begin
      rem_sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      sub_t  = rem_sh - {1'b0, dvs};
      if (sub_t[WIDTH])
        p_step = {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      else
        p_step = {sub_t[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      p      <= '0;
      dvs    <= '0;
      md     <= MD_MUL;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt    <= '0;
      md     <= mode;
      dvs    <= b;
      p      <= {{WIDTH{1'b0}}, a};
    end else if (busy_q) begin
      p   <= p_step;
      cnt <= cnt + 1'b1;
      if (cnt == LAST)
        busy_q <= 1'b0;
    end
  end

  // lo/hi present the outcome of the final step while done is high, so the
  // caller can register it on the same edge the step completes.
  assign busy = busy_q;
  assign done = busy_q && (cnt == LAST);
  assign lo   = p_step[WIDTH-1:0];
  assign hi   = p_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_multicycle.sv
// Parametrised ALU with single-cycle logic/arithmetic ops and iterative
// MUL/DIV, using valid/ready handshakes on both sides.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dbz
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_n;
  logic             accept;
  logic             eng_start, eng_busy, eng_done;
  logic [WIDTH-1:0] eng_lo, eng_hi;

  logic [SHW-1:0]   amt, ramt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_carry, sc_ovf, sc_dbz;

  logic             load;
  logic [WIDTH-1:0] res_n, hi_n;
  logic             carry_n, ovf_n, dbz_n;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (eng_start),
    .mode    ((opcode == OP_MUL) ? MD_MUL : MD_DIV),
    .a       (operand1),
    .b       (operand2),
    .busy    (eng_busy),
    .done    (eng_done),
    .lo      (eng_lo),
    .hi      (eng_hi)
  );

  always_comb begin
    amt      = operand2[SHW-1:0];
    ramt     = '0 - amt;
    sum      = {1'b0, operand1} + {1'b0, operand2};
    diff     = {1'b0, operand1} - {1'b0, operand2};
    sc_res   = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dbz   = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (diff[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_DIV: begin
        sc_res = '1;
        sc_hi  = operand1;
        sc_dbz = 1'b1;
      end
      OP_SHL:  sc_res = operand1 << amt;
      OP_SHR:  sc_res = operand1 >> amt;
      // ramt is (WIDTH - amt) mod WIDTH, so amount 0 ORs operand1 with itself
      OP_ROL:  sc_res = (operand1 << amt) | (operand1 >> ramt);
      OP_ROR:  sc_res = (operand1 >> amt) | (operand1 << ramt);
      OP_AND:  sc_res = operand1 & operand2;
      OP_OR:   sc_res = operand1 | operand2;
      OP_XOR:  sc_res = operand1 ^ operand2;
      OP_NOR:  sc_res = ~(operand1 | operand2);
      OP_NAND: sc_res = ~(operand1 & operand2);
      OP_XNOR: sc_res = ~(operand1 ^ operand2);
      OP_GT:   sc_res[0] = (operand1 > operand2);
      OP_EQ:   sc_res[0] = (operand1 == operand2);
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    eng_start = 1'b0;
    res_n     = sc_res;
    hi_n      = sc_hi;
    carry_n   = sc_carry;
    ovf_n     = sc_ovf;
    dbz_n     = sc_dbz;
    case (state)
      ST_IDLE, ST_DONE: begin
        if ((state == ST_DONE) && out_ready)
          state_n = ST_IDLE;
        if (accept) begin
          if (is_multicycle(opcode) && (operand2 != '0 || opcode == OP_MUL)) begin
            eng_start = 1'b1;
            state_n   = (opcode == OP_MUL) ? ST_MUL : ST_DIV;
          end else begin
            load    = 1'b1;
            state_n = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (eng_done) begin
          load    = 1'b1;
          res_n   = eng_lo;
          hi_n    = eng_hi;
          carry_n = (state == ST_MUL) && (eng_hi != '0);
          ovf_n   = 1'b0;
          dbz_n   = 1'b0;
          state_n = ST_DONE;
        end else if (!eng_busy) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      result     <= '0;
      result_hi  <= '0;
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_dbz   <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        result     <= res_n;
        result_hi  <= hi_n;
        flag_zero  <= (res_n == '0);
        flag_neg   <= res_n[WIDTH-1];
        flag_carry <= carry_n;
        flag_ovf   <= ovf_n;
        flag_dbz   <= dbz_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised bench for alu_multicycle (WIDTH=16) checked against an
// arithmetic reference model and a transaction queue.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] operand1, operand2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result, result_hi;
  logic        flag_zero, flag_neg, flag_carry, flag_ovf, flag_dbz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [4:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  bit          seen = 1'b0;
  bit          hold = 1'b0;
  logic [36:0] prev_out;

  alu_multicycle #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .operand1   (operand1),
    .operand2   (operand2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_dbz   (flag_dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Flags packed as {zero, neg, carry, ovf, dbz}.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int unsigned ua, ub, amt, r, h;
    int          sa, sb, s;
    logic        c, o, d;
    ua = a; ub = b; amt = ub % 16;
    sa = $signed(a); sb = $signed(b);
    r = 0; h = 0; c = 0; o = 0; d = 0;
    e.lat = 1; e.acc = 0;
    case (op)
      OP_ADD: begin r = ua + ub; c = (r > 65535); s = sa + sb; o = (s > 32767) || (s < -32768); end
      OP_SUB: begin r = ua - ub; c = (ua < ub); s = sa - sb; o = (s > 32767) || (s < -32768); end
      OP_MUL: begin r = ua * ub; h = r >> 16; c = (h != 0); e.lat = 17; end
      OP_DIV: begin
        if (ub == 0) begin r = 65535; h = ua; d = 1; end
        else begin r = ua / ub; h = ua % ub; e.lat = 17; end
      end
      OP_SHL:  r = ua << amt;
      OP_SHR:  r = ua >> amt;
      OP_ROL:  r = (ua << amt) | (ua >> (16 - amt));
      OP_ROR:  r = (ua >> amt) | (ua << (16 - amt));
      OP_AND:  r = ua & ub;
      OP_OR:   r = ua | ub;
      OP_XOR:  r = ua ^ ub;
      OP_NOR:  r = ~(ua | ub);
      OP_NAND: r = ~(ua & ub);
      OP_XNOR: r = ~(ua ^ ub);
      OP_GT:   r = (ua > ub) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    e.res = r[15:0];
    e.hi  = h[15:0];
    e.fl  = {(e.res == 16'h0), e.res[15], c, o, d};
    return e;
  endfunction

  always @(negedge clk) begin
    logic [36:0] cur;
    exp_t        e;
    cur = {result, result_hi, flag_zero, flag_neg, flag_carry, flag_ovf, flag_dbz};
    if (!reset_n) begin
      q.delete();
      seen = 1'b0;
      hold = 1'b0;
    end else begin
      if (hold)
        chk("hold_stable", cur, prev_out);
      if (q.size() == 0) begin
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_in_ready", in_ready, 1'b1);
      end else if (!out_valid) begin
        chk("busy_in_ready", in_ready, 1'b0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - q[0].acc, q[0].lat);
          chk("result", result, q[0].res);
          chk("result_hi", result_hi, q[0].hi);
          chk("flags", cur[4:0], q[0].fl);
          seen = 1'b1;
        end
        chk("done_in_ready", in_ready, out_ready);
      end
      hold     = out_valid && !out_ready;
      prev_out = cur;
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        e     = model(opcode, operand1, operand2);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready)
      out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    opcode   = op;
    operand1 = a;
    operand2 = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      tick();
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept op=%0h", op);
    end
    tick();
    in_valid = 1'b0;
    opcode   = 4'($urandom);
    operand1 = 16'($urandom);
    operand2 = 16'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=pending required=idle");
    end
    tick();
  endtask

  initial begin
    exp_t e;
    logic [15:0] a, b;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    opcode    = '0;
    operand1  = '0;
    operand2  = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {result, result_hi, flag_zero, flag_neg, flag_carry, flag_ovf, flag_dbz}, '0);
    chk("rst_in_ready", in_ready, 1'b1);

    e = model(OP_ADD, 16'hFFFF, 16'h0001); chk("pin_add",  {e.res, e.hi, e.fl}, {16'h0000, 16'h0000, 5'b10100});
    e = model(OP_SUB, 16'h8000, 16'h0001); chk("pin_sub",  {e.res, e.hi, e.fl}, {16'h7FFF, 16'h0000, 5'b00010});
    e = model(OP_MUL, 16'h1234, 16'h0100); chk("pin_mul",  {e.res, e.hi, e.fl, 8'(e.lat)}, {16'h3400, 16'h0012, 5'b00100, 8'd17});
    e = model(OP_DIV, 16'd100, 16'd7);     chk("pin_div",  {e.res, e.hi, e.fl, 8'(e.lat)}, {16'd14, 16'd2, 5'b00000, 8'd17});
    e = model(OP_DIV, 16'd5, 16'd0);       chk("pin_dbz",  {e.res, e.hi, e.fl, 8'(e.lat)}, {16'hFFFF, 16'd5, 5'b01001, 8'd1});
    e = model(OP_ROL, 16'h8001, 16'd4);    chk("pin_rol",  {e.res, e.fl}, {16'h0018, 5'b00000});
    e = model(OP_ROR, 16'h8001, 16'd0);    chk("pin_ror0", e.res, 16'h8001);
    tick();

    issue(OP_ADD, 16'hFFFF, 16'h0001);
    issue(OP_SUB, 16'h8000, 16'h0001);
    issue(OP_MUL, 16'h1234, 16'h0100);
    drain();
    issue(OP_DIV, 16'd100, 16'd7);
    issue(OP_DIV, 16'd5, 16'd0);
    drain();

    out_ready = 1'b0;
    issue(OP_ROL, 16'h8001, 16'd4);
    repeat (5) tick();
    out_ready = 1'b1;
    issue(OP_AND, 16'hF0F0, 16'h3C3C);
    drain();

    issue(OP_MUL, 16'hBEEF, 16'h1234);
    repeat (8) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    issue(OP_ADD, 16'd2, 16'd3);
    drain();

    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      issue(4'($urandom), a, b);
    end
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
